// File: rtl/adt7420_i2c_target.sv
// ADT7420-style I2C target: oversampled scl/sda, open-drain sda, register map
// with live temperature capture and RW threshold/config registers.
module adt7420_i2c_target #(
    parameter logic [6:0] BUS_ADDR = 7'b1001000,
    parameter int         SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scl,
    inout  wire         sda,
    input  logic [15:0] temp_value,
    input  logic        temp_load,
    input  logic [7:0]  status_in,
    output logic        busy,
    output logic        wr_strobe,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t              state, state_nxt;
    logic [SYNC_STG-1:0] scl_sync, sda_sync;
    logic                scl_s, sda_s, scl_d, sda_d;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [2:0]          cnt;
    logic [6:0]          sh;
    logic [7:0]          tx, ptr, rx_byte;
    logic                drive, drv_nxt;
    logic                last_bit, addr_hit, wr_hit, ptr_rw;
    logic [2:0]          rw_idx;
    logic [7:0]          rw_reg [8];
    logic [15:0]         temp, temp_hold;
    logic                temp_pend;

    function automatic logic [7:0] rw_default(input logic [2:0] i);
        case (i)
            3'd1:    rw_default = 8'h20;
            3'd3:    rw_default = 8'h05;
            3'd5:    rw_default = 8'h49;
            3'd6:    rw_default = 8'h80;
            3'd7:    rw_default = 8'h05;
            default: rw_default = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] rd_mux(input logic [7:0] a);
        logic [2:0] off;
        off    = a[2:0] - 3'd3;
        rd_mux = 8'h00;
        if (a == 8'h00)                    rd_mux = temp[15:8];
        else if (a == 8'h01)               rd_mux = temp[7:0];
        else if (a == 8'h02)               rd_mux = status_in;
        else if (a == 8'h0B)               rd_mux = 8'hCB;
        else if (a >= 8'h03 && a <= 8'h0A) rd_mux = rw_reg[off];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STG-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STG-2:0], sda};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STG-1];
    assign sda_s     = sda_sync[SYNC_STG-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign last_bit  = (cnt == 3'd7);
    assign rx_byte   = {sh, sda_s};
    assign addr_hit  = (sh == BUS_ADDR);
    assign ptr_rw    = (ptr >= 8'h03) && (ptr <= 8'h0A);
    assign rw_idx    = ptr[2:0] - 3'd3;
    assign wr_hit    = scl_rise && (state == WR_DATA) && last_bit;
    assign sda       = drive ? 1'b0 : 1'bz;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop_det) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = ADDR;
        end else if (scl_rise) begin
            case (state)
                ADDR:     if (last_bit) state_nxt = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK: state_nxt = sh[0] ? RD_DATA : PTR;
                PTR:      if (last_bit) state_nxt = PTR_ACK;
                PTR_ACK:  state_nxt = WR_DATA;
                WR_DATA:  if (last_bit) state_nxt = WR_ACK;
                WR_ACK:   state_nxt = WR_DATA;
                RD_DATA:  if (last_bit) state_nxt = RD_ACK;
                RD_ACK:   state_nxt = sda_s ? IGNORE : RD_DATA;
                default:  state_nxt = state;
            endcase
        end
    end

    // Value put on sda at the next scl fall, chosen by the phase being entered
    always_comb begin
        drv_nxt = 1'b0;
        case (state)
            ADDR_ACK, PTR_ACK, WR_ACK: drv_nxt = 1'b1;
            RD_DATA:                   drv_nxt = ~tx[7];
            default:                   drv_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            sh    <= '0;
            tx    <= '0;
            ptr   <= '0;
            drive <= 1'b0;
            busy  <= 1'b0;
        end else if (start_det || stop_det) begin
            cnt   <= '0;
            drive <= 1'b0;
            if (stop_det) busy <= 1'b0;
        end else begin
            if (scl_fall) begin
                drive <= drv_nxt;
                if (state == RD_DATA) tx <= {tx[6:0], 1'b0};
            end
            if (scl_rise) begin
                if (state inside {ADDR, PTR, WR_DATA, RD_DATA}) begin
                    sh  <= rx_byte[6:0];
                    cnt <= cnt + 3'd1;
                end
                if (state == ADDR && last_bit && addr_hit) busy <= 1'b1;
                if (state == PTR && last_bit) ptr <= rx_byte;
                if (state == WR_DATA && last_bit) ptr <= ptr + 8'd1;
                if (state == ADDR_ACK && sh[0]) tx <= rd_mux(ptr);
                if (state == RD_ACK && !sda_s) begin
                    ptr <= ptr + 8'd1;
                    tx  <= rd_mux(ptr + 8'd1);
                end
            end
        end
    end

    // Temperature captured mid-transaction is held until the bus goes idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) rw_reg[i] <= rw_default(3'(i));
            temp      <= '0;
            temp_hold <= '0;
            temp_pend <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (wr_hit && ptr_rw) begin
                rw_reg[rw_idx] <= rx_byte;
                wr_strobe      <= 1'b1;
                wr_addr        <= ptr;
                wr_data        <= rx_byte;
            end else if (wr_hit && ptr == 8'h2F) begin
                for (int i = 0; i < 8; i++) rw_reg[i] <= rw_default(3'(i));
            end
            if (temp_load && !busy) begin
                temp      <= temp_value;
                temp_pend <= 1'b0;
            end else if (temp_load) begin
                temp_hold <= temp_value;
                temp_pend <= 1'b1;
            end else if (temp_pend && !busy) begin
                temp      <= temp_hold;
                temp_pend <= 1'b0;
            end
        end
    end

endmodule
